// File: rtl/spectrum_frame_buf_pkg.sv
// Shared types and constants for the spectrum frame buffer.
package spectrum_frame_buf_pkg;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_CAPTURE = 2'd1,
        W_SKIP    = 2'd2,
        W_FULL    = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_WAIT  = 2'd2
    } rd_state_e;

    localparam int MAG_RAW = 0;
    localparam int MAG_ABS = 1;

endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; bank select is the address MSB.
// The read port is registered (one-cycle latency) and only its output register is reset.
module spectrum_bank_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: memory contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output clears on reset so rd_data reads zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spectrum_frame_buf.sv
// Ping-pong spectrum frame buffer: captures the first BINS samples of each FFT frame
// into a write bank and serves bins one at a time from the read bank.
//
//  state     | meaning
//  W_IDLE    | waiting for sop
//  W_CAPTURE | writing samples 0..BINS-1
//  W_SKIP    | discarding the rest of the frame until eop
//  W_FULL    | write bank holds a complete frame, waiting for swap
//  R_IDLE    | waiting for data_req
//  R_FETCH   | RAM read in flight
//  R_WAIT    | bin presented, waiting for wr_over
module spectrum_frame_buf
    import spectrum_frame_buf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int FFT_LEN  = 256,
    parameter int BINS     = FFT_LEN / 2,
    parameter int MAG_MODE = MAG_RAW,
    localparam int ADDR_W  = $clog2(BINS)
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fft_data,
    input  logic              fft_sop,
    input  logic              fft_eop,
    input  logic              fft_valid,
    input  logic              data_req,
    input  logic              wr_over,
    input  logic              freeze,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_bin,
    output logic              frame_avail,
    output logic [7:0]        drop_cnt,
    output logic              short_err
);

    localparam int HALF_W = DATA_W / 2;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_bin_q, rd_bin_d;
    logic              wr_bank_q, wr_bank_d;
    logic              frame_avail_q, frame_avail_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              short_err_q, short_err_d;
    logic              rd_valid_q, rd_valid_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] wr_word;

    logic in_sop, in_eop, last_bin, swap;

    assign in_sop   = fft_valid & fft_sop;
    assign in_eop   = fft_valid & fft_eop;
    assign last_bin = (wr_ptr_q == ADDR_W'(BINS - 1));
    // Swapping only while the reader sits idle at bin 0 keeps a sweep from mixing frames.
    assign swap     = (wr_state_q == W_FULL) && (rd_state_q == R_IDLE) &&
                      (rd_ptr_q == '0) && !freeze;

    // |re|+|im| is one bit wider than a half-word so -2^(N-1) needs no saturation.
    logic signed [HALF_W:0] re_x, im_x;
    logic        [HALF_W:0] re_abs, im_abs, mag_sum;

    assign re_x    = {fft_data[DATA_W-1], fft_data[DATA_W-1 -: HALF_W]};
    assign im_x    = {fft_data[HALF_W-1], fft_data[HALF_W-1:0]};
    assign re_abs  = re_x[HALF_W] ? -re_x : re_x;
    assign im_abs  = im_x[HALF_W] ? -im_x : im_x;
    assign mag_sum = re_abs + im_abs;
    assign wr_word = (MAG_MODE == MAG_ABS) ? {{(DATA_W-HALF_W-1){1'b0}}, mag_sum} : fft_data;

    // State and datapath registers.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            wr_state_q    <= W_IDLE;
            rd_state_q    <= R_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_bin_q      <= '0;
            wr_bank_q     <= 1'b0;
            frame_avail_q <= 1'b0;
            drop_cnt_q    <= '0;
            short_err_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            rd_state_q    <= rd_state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_bin_q      <= rd_bin_d;
            wr_bank_q     <= wr_bank_d;
            frame_avail_q <= frame_avail_d;
            drop_cnt_q    <= drop_cnt_d;
            short_err_q   <= short_err_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Write FSM next state and capture pointer.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        case (wr_state_q)
            W_IDLE: begin
                if (in_sop) begin
                    wr_state_d = W_CAPTURE;
                    wr_ptr_d   = ADDR_W'(1);
                end
            end
            W_CAPTURE: begin
                if (in_sop) begin
                    wr_ptr_d = ADDR_W'(1);
                end else if (fft_valid) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (last_bin) begin
                        wr_state_d = fft_eop ? W_FULL : W_SKIP;
                        wr_ptr_d   = '0;
                    end else if (fft_eop) begin
                        wr_state_d = W_IDLE;
                        wr_ptr_d   = '0;
                    end
                end
            end
            W_SKIP: begin
                if (in_sop) begin
                    wr_state_d = W_CAPTURE;
                    wr_ptr_d   = ADDR_W'(1);
                end else if (in_eop) begin
                    wr_state_d = W_FULL;
                end
            end
            W_FULL: begin
                if (swap) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = '0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write-side outputs: RAM strobe, error pulse, drop counter and bank swap.
    always_comb begin
        ram_we        = 1'b0;
        ram_waddr     = wr_ptr_q;
        short_err_d   = 1'b0;
        drop_cnt_d    = drop_cnt_q;
        wr_bank_d     = swap ? ~wr_bank_q : wr_bank_q;
        frame_avail_d = frame_avail_q | swap;
        case (wr_state_q)
            W_IDLE: begin
                if (in_sop) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                end
            end
            W_CAPTURE: begin
                if (in_sop) begin
                    ram_we      = 1'b1;
                    ram_waddr   = '0;
                    short_err_d = 1'b1;
                end else if (fft_valid) begin
                    ram_we      = 1'b1;
                    short_err_d = fft_eop & ~last_bin;
                end
            end
            W_SKIP: begin
                if (in_sop) begin
                    ram_we      = 1'b1;
                    ram_waddr   = '0;
                    short_err_d = 1'b1;
                end
            end
            W_FULL: begin
                if (in_sop && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Read FSM: fetch one bin per request, advance on wr_over.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bin_d   = rd_bin_q;
        rd_valid_d = 1'b0;
        ram_re     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (data_req && frame_avail_q) begin
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re     = 1'b1;
                rd_valid_d = 1'b1;
                rd_bin_d   = rd_ptr_q;
                rd_state_d = R_WAIT;
            end
            R_WAIT: begin
                if (wr_over) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = (rd_ptr_q == ADDR_W'(BINS - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    spectrum_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * BINS)
    ) u_ram (
        .clk_i   (clk_50m),
        .rst_n_i (rst_n),
        .we_i    (ram_we),
        .waddr_i ({wr_bank_q, ram_waddr}),
        .wdata_i (wr_word),
        .re_i    (ram_re),
        .raddr_i ({~wr_bank_q, rd_ptr_q}),
        .rdata_o (ram_rdata)
    );

    assign rd_data     = ram_rdata;
    assign rd_valid    = rd_valid_q;
    assign rd_bin      = rd_bin_q;
    assign frame_avail = frame_avail_q;
    assign drop_cnt    = drop_cnt_q;
    assign short_err   = short_err_q;

endmodule

// File: tb/tb_spectrum_frame_buf.sv
// Directed bench for spectrum_frame_buf: a raw-mode and a magnitude-mode instance share stimulus.
module tb_spectrum_frame_buf;

    localparam int DATA_W = 32;
    localparam int BINS   = 128;

    logic              clk_50m = 1'b0;
    logic              rst_n, fft_sop, fft_eop, fft_valid, data_req, wr_over, freeze;
    logic [DATA_W-1:0] fft_data;

    logic [DATA_W-1:0] rd_data, m_rd_data;
    logic              rd_valid, m_rd_valid;
    logic [6:0]        rd_bin, m_rd_bin;
    logic              frame_avail, m_frame_avail;
    logic [7:0]        drop_cnt, m_drop_cnt;
    logic              short_err, m_short_err;

    int n_chk = 0;
    int n_fail = 0;
    int se_cnt = 0;
    int rv_cnt = 0;
    logic [31:0] samp [256];
    logic [31:0] mag_seen;
    logic [31:0] mag_bin;

    always #10 clk_50m = ~clk_50m;

    spectrum_frame_buf #(.DATA_W(32), .FFT_LEN(256), .MAG_MODE(0)) u_dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .fft_data(fft_data), .fft_sop(fft_sop),
        .fft_eop(fft_eop), .fft_valid(fft_valid), .data_req(data_req), .wr_over(wr_over),
        .freeze(freeze), .rd_data(rd_data), .rd_valid(rd_valid), .rd_bin(rd_bin),
        .frame_avail(frame_avail), .drop_cnt(drop_cnt), .short_err(short_err)
    );

    spectrum_frame_buf #(.DATA_W(32), .FFT_LEN(256), .MAG_MODE(1)) u_mag (
        .clk_50m(clk_50m), .rst_n(rst_n), .fft_data(fft_data), .fft_sop(fft_sop),
        .fft_eop(fft_eop), .fft_valid(fft_valid), .data_req(data_req), .wr_over(wr_over),
        .freeze(freeze), .rd_data(m_rd_data), .rd_valid(m_rd_valid), .rd_bin(m_rd_bin),
        .frame_avail(m_frame_avail), .drop_cnt(m_drop_cnt), .short_err(m_short_err)
    );

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk_50m) begin
        if (short_err === 1'b1) se_cnt++;
        if (rd_valid === 1'b1) rv_cnt++;
    end

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] exp_mag;
    } mag_vec_t;

    mag_vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic put_sample(input logic [31:0] d, input logic sop, input logic eop);
        fft_data  = d;
        fft_sop   = sop;
        fft_eop   = eop;
        fft_valid = 1'b1;
        step();
        fft_valid = 1'b0;
        fft_sop   = 1'b0;
        fft_eop   = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 256; i++) samp[i] = base + 32'(i);
    endtask

    // Sends samp[0..n-1]; two idle cycles afterwards let a pending swap land.
    task automatic send_frame(input int n, input logic with_sop, input logic with_eop);
        for (int i = 0; i < n; i++) put_sample(samp[i], with_sop && (i == 0), with_eop && (i == n - 1));
        repeat (2) step();
    endtask

    task automatic read_bin(input logic [31:0] exp_d, input int exp_b);
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        chk("rd_valid_early", 32'(rd_valid), 32'd0);
        step();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, exp_d);
        chk("rd_bin", 32'(rd_bin), 32'(exp_b));
        mag_seen = m_rd_data;
        mag_bin  = 32'(m_rd_bin);
        step();
        chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
        wr_over = 1'b1;
        step();
        wr_over = 1'b0;
    endtask

    task automatic chk_ignored_req(input string nm);
        int base;
        base = rv_cnt;
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        repeat (4) step();
        chk(nm, 32'(rv_cnt - base), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_bin"}, 32'(rd_bin), 32'd0);
        chk({tag, "_frame_avail"}, 32'(frame_avail), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_short_err"}, 32'(short_err), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{16'hFFFD, 16'h0005, 32'd8};
        vecs[1] = '{16'h8000, 16'h0000, 32'd32768};
        vecs[2] = '{16'h0000, 16'h0000, 32'd0};
        vecs[3] = '{16'h7FFF, 16'h8000, 32'd65535};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 32'd2};
        vecs[5] = '{16'd100,  16'hFFCE, 32'd150};

        rst_n = 1'b0; fft_data = '0; fft_sop = 1'b0; fft_eop = 1'b0; fft_valid = 1'b0;
        data_req = 1'b0; wr_over = 1'b0; freeze = 1'b0;

        // Reset state
        do_reset(3);
        chk_zero_outputs("rst");
        chk("rst_m_rd_data", m_rd_data, 32'd0);
        chk("rst_m_rd_valid", 32'(m_rd_valid), 32'd0);
        chk("rst_m_rd_bin", 32'(m_rd_bin), 32'd0);
        chk("rst_m_frame_avail", 32'(m_frame_avail), 32'd0);
        chk("rst_m_drop_cnt", 32'(m_drop_cnt), 32'd0);
        chk("rst_m_short_err", 32'(m_short_err), 32'd0);

        // Full frame with data=index, one complete sweep
        fill(32'd0);
        send_frame(256, 1'b1, 1'b1);
        chk("frame_avail_1", 32'(frame_avail), 32'd1);
        for (int i = 0; i < BINS; i++) read_bin(32'(i), i);

        // Short frame, restart mid-capture, ignored request without a frame
        do_reset(1);
        base = se_cnt;
        fill(32'hDEAD_0000);
        send_frame(50, 1'b1, 1'b1);
        chk("short_err_count", 32'(se_cnt - base), 32'd1);
        chk("short_err_cleared", 32'(short_err), 32'd0);
        chk("short_frame_avail", 32'(frame_avail), 32'd0);
        chk_ignored_req("req_no_frame");
        send_frame(20, 1'b1, 1'b0);
        fill(32'h0001_0000);
        send_frame(256, 1'b1, 1'b1);
        chk("restart_short_err", 32'(se_cnt - base), 32'd2);
        chk("restart_frame_avail", 32'(frame_avail), 32'd1);
        for (int i = 0; i < 4; i++) read_bin(32'h0001_0000 + 32'(i), i);

        // New frame completes mid-sweep: swap waits for rd_ptr wrap
        do_reset(1);
        fill(32'hA000_0000);
        send_frame(256, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) read_bin(32'hA000_0000 + 32'(i), i);
        fill(32'hB000_0000);
        send_frame(256, 1'b1, 1'b1);
        for (int i = 60; i < BINS; i++) read_bin(32'hA000_0000 + 32'(i), i);
        for (int i = 0; i < 4; i++) read_bin(32'hB000_0000 + 32'(i), i);

        // Freeze: frames stall, drops counted and saturate, frame 2 shows after unfreeze + wrap
        do_reset(1);
        fill(32'h1111_0000);
        send_frame(256, 1'b1, 1'b1);
        freeze = 1'b1;
        fill(32'h2222_0000);
        send_frame(256, 1'b1, 1'b1);
        fill(32'h3333_0000);
        send_frame(256, 1'b1, 1'b1);
        fill(32'h4444_0000);
        send_frame(256, 1'b1, 1'b1);
        for (int i = 0; i < 2 * BINS; i++) read_bin(32'h1111_0000 + 32'(i % BINS), i % BINS);
        chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 10; i++) read_bin(32'h1111_0000 + 32'(i), i);
        for (int i = 0; i < 260; i++) put_sample(32'h0, 1'b1, 1'b0);
        step();
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        freeze = 1'b0;
        for (int i = 10; i < BINS; i++) read_bin(32'h1111_0000 + 32'(i), i);
        for (int i = 0; i < 4; i++) read_bin(32'h2222_0000 + 32'(i), i);

        // One-cycle reset during capture at sample 40
        fill(32'h6666_0000);
        send_frame(40, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_zero_outputs("midrst");
        send_frame(216, 1'b0, 1'b1);
        chk("midrst_no_avail", 32'(frame_avail), 32'd0);
        chk_ignored_req("midrst_req_ignored");
        fill(32'h7777_0000);
        send_frame(256, 1'b1, 1'b1);
        chk("midrst_frame_avail", 32'(frame_avail), 32'd1);
        for (int i = 0; i < 8; i++) read_bin(32'h7777_0000 + 32'(i), i);

        // Magnitude table; exactly BINS samples with eop on the last one
        do_reset(1);
        fill(32'd0);
        for (int i = 0; i < 6; i++) samp[i] = {vecs[i].re, vecs[i].im};
        send_frame(BINS, 1'b1, 1'b1);
        chk("eop_at_last_avail", 32'(frame_avail), 32'd1);
        for (int i = 0; i < 6; i++) begin
            read_bin({vecs[i].re, vecs[i].im}, i);
            chk("mag_data", mag_seen, vecs[i].exp_mag);
            chk("mag_bin", mag_bin, 32'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spectrum_frame_buf.md
SPECTRUM_FRAME_BUF -- requirements
Module: spectrum_frame_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the FFT sample width as {re[DATA_W/2-1:0], im[DATA_W/2-1:0]}.
REQ-002 The block SHALL have parameter FFT_LEN, default 256, meaning the transform length (power of two).
REQ-003 The block SHALL have parameter BINS, default FFT_LEN/2, meaning the number of bins kept per frame; ADDR_W=$clog2(BINS).
REQ-004 The block SHALL have parameter MAG_MODE, default 0, where 0 stores raw samples and 1 stores |re|+|im| (unsigned, DATA_W/2+1 bits, zero-extended to DATA_W).
REQ-005 The block SHALL have port clk_50m, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have ports fft_data (input, DATA_W), fft_sop, fft_eop and fft_valid (inputs, 1 each): the FFT output stream.
REQ-008 The block SHALL have port data_req, input, 1 bit: a one-cycle request for the next bin.
REQ-009 The block SHALL have port wr_over, input, 1 bit: the consumer has finished drawing the current bin.
REQ-010 The block SHALL have port freeze, input, 1 bit: hold the displayed frame.
REQ-011 The block SHALL have output ports rd_data (DATA_W), rd_valid (1), rd_bin (ADDR_W), frame_avail (1), drop_cnt (8) and short_err (1).

Function
REQ-012 Storage SHALL be two banks of BINS words (ping-pong): one write bank and one read bank.
REQ-013 The write FSM SHALL have states W_IDLE, W_CAPTURE, W_SKIP and W_FULL.
REQ-014 W_IDLE: a cycle with fft_valid&&fft_sop SHALL write that sample to address 0 and go to W_CAPTURE; valid samples without sop SHALL be ignored.
REQ-015 W_CAPTURE: each valid sample SHALL be written at wr_ptr; after the write at BINS-1 the FSM SHALL go to W_SKIP, or to W_FULL if that sample carries eop.
REQ-016 W_SKIP: valid samples SHALL be discarded until fft_eop, then the FSM SHALL go to W_FULL.
REQ-017 In W_CAPTURE, eop before BINS samples SHALL abandon the frame, pulse short_err for one cycle, and return to W_IDLE.
REQ-018 In W_CAPTURE or W_SKIP, a new sop SHALL restart capture at address 0 and pulse short_err.
REQ-019 W_FULL: input samples SHALL be ignored; a sop arriving here SHALL increment drop_cnt, saturating at 255.
REQ-020 A bank swap SHALL occur in the cycle where the write FSM is in W_FULL, the read FSM is in R_IDLE with rd_ptr==0, and freeze==0; after the swap, frame_avail=1 and the write FSM returns to W_IDLE.
REQ-021 The read FSM SHALL have states R_IDLE, R_FETCH and R_WAIT.
REQ-022 R_IDLE: data_req with frame_avail=1 SHALL move to R_FETCH; data_req with frame_avail=0 SHALL be ignored.
REQ-023 R_FETCH: the memory read SHALL complete, and on the next cycle rd_valid SHALL pulse for one cycle with rd_data=bank[rd_ptr] and rd_bin=rd_ptr (2-cycle latency from data_req); the FSM SHALL then go to R_WAIT.
REQ-024 R_WAIT: wr_over SHALL return the FSM to R_IDLE; rd_ptr SHALL increment, wrapping from BINS-1 to 0.
REQ-025 data_req while not in R_IDLE SHALL be ignored.
REQ-026 While freeze=1, the read bank SHALL be re-read cyclically, no swap SHALL occur, and incoming completed frames SHALL stall in W_FULL, so later sops count as drops.
REQ-027 In MAG_MODE=1, |x| SHALL use two's-complement negation; |-2^(N-1)| SHALL equal 2^(N-1), with no saturation needed given the extra bit.

Reset
REQ-028 When rst_n=0 at a clock edge, both FSMs SHALL go idle, all pointers SHALL clear, and rd_valid=0, rd_data=0, rd_bin=0, frame_avail=0, drop_cnt=0 and short_err=0; memory contents SHALL need no reset.
REQ-029 Reset mid-frame SHALL discard the partial frame and any full bank; frame_avail SHALL stay 0 until the next complete frame swaps in.

Structure
REQ-030 A shared package SHALL hold the write/read state encodings and the MAG_MODE constants.
REQ-031 A single sub-module spectrum_bank_ram (simple dual-port RAM, one-cycle registered read, 2*BINS words) SHALL hold both banks, with the bank select as the address MSB.

Verification
REQ-032 Scenario: reset, one 256-sample frame with data=index, then 128 data_req/wr_over handshakes -> rd_data 0..127, rd_bin 0..127, each rd_valid exactly 2 cycles after data_req.
REQ-033 Scenario: eop after 50 samples -> short_err pulses once, frame_avail stays 0, and data_req produces no rd_valid.
REQ-034 Scenario: freeze=1 while 3 further frames arrive -> rd_data repeats frame 1 across 2 full sweeps, drop_cnt=2, and after freeze=0 plus a rd_ptr wrap the second frame is displayed.
REQ-035 Scenario: MAG_MODE=1 with sample {re=-3, im=5} -> rd_data=8; with {re=-32768, im=0} -> rd_data=32768.
REQ-036 Scenario: frame completes while the reader is mid-sweep at bin 60 -> no swap until rd_ptr wraps to 0, then the new frame data is read from bin 0.
REQ-037 Scenario: rst_n low for 1 cycle during W_CAPTURE at sample 40 -> all outputs zero, and the next full frame is captured correctly from bin 0.
